boc_corr_accum: RTL
===================

# boc_corr_accum

Integrate-and-dump correlator that consumes the local BOC/PRN replica and code-period markers from the local code generator and correlates them against incoming baseband I/Q samples. It accumulates one correlation value per code period (SOP to EOP) and presents it to the tracking-loop logic through a valid/ready dump interface. It sits between the code NCO/replica generator and the discriminator/loop-filter stage of each tracking channel.

## Interface
- SAMPLE_WIDTH, 4, signed two's-complement width of rx_smp_i / rx_smp_q
- ACC_WIDTH, 24, signed width of each correlation accumulator (ACC_WIDTH > SAMPLE_WIDTH)
- CNT_WIDTH, 16, width of the per-period sample counter

- rx_clk  in  1  clock
- rx_rst_n  in  1  reset, asynchronous, active-low
- rx_en  in  1  correlator enable
- rx_smp_valid  in  1  sample strobe; all replica/marker inputs qualified by it
- rx_smp_i, rx_smp_q  in  SAMPLE_WIDTH  signed baseband sample
- rx_loc_prn  in  1  local PRN chip (0 = +1, 1 = -1)
- rx_loc_boc  in  1  local BOC subcarrier (0 = +1, 1 = -1)
- rx_prn_sop  in  1  sample is first of a code period
- rx_prn_eop  in  1  sample is last of a code period
- rx_dump_ready  in  1  consumer accepts dump
- tx_dump_valid  out  1  dump result available
- tx_corr_i, tx_corr_q  out  ACC_WIDTH  signed correlation results
- tx_smp_cnt  out  CNT_WIDTH  samples accumulated in the dumped period
- tx_overrun  out  1  one-cycle pulse: unacknowledged dump overwritten
- tx_sync_err  out  1  one-cycle pulse: SOP seen mid-period, partial period discarded

## Operation
- Replica sign s = rx_loc_prn XOR rx_loc_boc; product = s ? -x : x, per channel, sign-extended to ACC_WIDTH before negation (−min sample representable).
- States: IDLE, WAIT_SOP, ACCUM.
- IDLE: entered on reset or rx_en=0 (from any state, takes priority). Accumulators and counter cleared. rx_en=1 -> WAIT_SOP.
- WAIT_SOP: samples ignored until rx_smp_valid & rx_prn_sop. That sample loads accumulators with its products, counter = 1; -> ACCUM, unless rx_prn_eop also set (single-sample period): dump immediately, stay WAIT_SOP.
- ACCUM: each valid sample adds products; counter increments.
  - valid & eop (no sop): include sample, dump, clear, -> WAIT_SOP.
  - valid & sop (no eop): tx_sync_err pulse; accumulators reloaded with this sample, counter = 1; stay ACCUM.
  - valid & sop & eop: tx_sync_err pulse; dump containing only this sample; -> WAIT_SOP.
- Accumulation saturates at signed max/min of ACC_WIDTH; counter saturates at all-ones.
- Dump: tx_corr_i/q and tx_smp_cnt load final values (including EOP sample); tx_dump_valid set. Output registers hold until handshake.
- Handshake: transfer when tx_dump_valid & rx_dump_ready; tx_dump_valid clears next cycle unless a new dump loads that cycle.
- New dump while tx_dump_valid=1 and rx_dump_ready=0: outputs overwritten, tx_dump_valid stays 1, tx_overrun pulses. Dump coinciding with ready=1: no overrun.
- rx_en=0 discards partial period but does not clear a pending dump.

## Timing
- Reset values: tx_dump_valid=0, tx_corr_i=0, tx_corr_q=0, tx_smp_cnt=0, tx_overrun=0, tx_sync_err=0, state IDLE.
- Dump latency: tx_dump_valid and results visible the cycle after the EOP sample is clocked.
- tx_sync_err / tx_overrun: asserted the cycle after the causing sample, for exactly one cycle.
- No combinational path from inputs to outputs; all outputs registered.
- Throughput: one sample per cycle sustained; back-to-back periods (EOP then SOP next cycle) lose no samples.
- Asynchronous reset mid-period: all state and outputs return to reset values immediately; no dump emitted.

## Test plan
- Period of 8 samples, I=+3, Q=−2, s=0 throughout, ready=1 -> one dump: corr_i=24, corr_q=−16, smp_cnt=8, one cycle after EOP.
- Same period with s alternating 0/1 (BOC) and I=+3 constant -> corr_i=0, corr_q=0, smp_cnt=8.
- Two back-to-back 4-sample periods, ready held 0 -> second dump overwrites first, tx_overrun pulses once, tx_dump_valid stays 1 until ready.
- SOP at sample 3 of a running period (I=+1) then EOP 2 samples later -> tx_sync_err pulse; dump corr_i=3, smp_cnt=3.
- ACC_WIDTH=8, I=+7, s=0, 40 samples -> corr_i saturates at 127, no wrap; I=−8, s=1 gives +8 per sample, also saturates at 127.
- Deassert rx_rst_n mid-period and drop rx_en mid-period (separately) -> no dump; next SOP..EOP period yields correct fresh values.

Source files
------------

// File: rtl/boc_corr_accum_if.sv
// Sample/replica input bus and dump output bus of one correlator channel.
// master: replica generator / loop side; slave: the correlator itself.
interface boc_corr_accum_if #(
    parameter int SAMPLE_WIDTH = 4,
    parameter int ACC_WIDTH    = 24,
    parameter int CNT_WIDTH    = 16
) ();
    logic                           rx_en;
    logic                           rx_smp_valid;
    logic signed [SAMPLE_WIDTH-1:0] rx_smp_i;
    logic signed [SAMPLE_WIDTH-1:0] rx_smp_q;
    logic                           rx_loc_prn;
    logic                           rx_loc_boc;
    logic                           rx_prn_sop;
    logic                           rx_prn_eop;
    logic                           rx_dump_ready;
    logic                           tx_dump_valid;
    logic signed [ACC_WIDTH-1:0]    tx_corr_i;
    logic signed [ACC_WIDTH-1:0]    tx_corr_q;
    logic [CNT_WIDTH-1:0]           tx_smp_cnt;
    logic                           tx_overrun;
    logic                           tx_sync_err;

    modport master (
        output rx_en, rx_smp_valid, rx_smp_i, rx_smp_q, rx_loc_prn, rx_loc_boc,
               rx_prn_sop, rx_prn_eop, rx_dump_ready,
        input  tx_dump_valid, tx_corr_i, tx_corr_q, tx_smp_cnt, tx_overrun, tx_sync_err
    );

    modport slave (
        input  rx_en, rx_smp_valid, rx_smp_i, rx_smp_q, rx_loc_prn, rx_loc_boc,
               rx_prn_sop, rx_prn_eop, rx_dump_ready,
        output tx_dump_valid, tx_corr_i, tx_corr_q, tx_smp_cnt, tx_overrun, tx_sync_err
    );
endinterface

// File: rtl/boc_corr_accum.sv
// Integrate-and-dump BOC/PRN correlator: one saturating I/Q correlation per code
// period (SOP..EOP), presented on a registered valid/ready dump port.
module boc_corr_accum #(
    parameter int SAMPLE_WIDTH = 4,
    parameter int ACC_WIDTH    = 24,
    parameter int CNT_WIDTH    = 16
) (
    input logic             rx_clk,
    input logic             rx_rst_n,
    boc_corr_accum_if.slave bus
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_SOP = 2'd1;
    localparam logic [1:0] ST_ACCUM    = 2'd2;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]        CNT_ONE = CNT_WIDTH'(1);

    logic [1:0]                  r_state;
    logic signed [ACC_WIDTH-1:0] r_acc_i;
    logic signed [ACC_WIDTH-1:0] r_acc_q;
    logic [CNT_WIDTH-1:0]        r_cnt;

    logic                        r_dump_valid;
    logic signed [ACC_WIDTH-1:0] r_corr_i;
    logic signed [ACC_WIDTH-1:0] r_corr_q;
    logic [CNT_WIDTH-1:0]        r_smp_cnt;
    logic                        r_overrun;
    logic                        r_sync_err;

    logic                        w_sign;
    logic                        w_smp_sop;
    logic signed [ACC_WIDTH-1:0] w_ext_i;
    logic signed [ACC_WIDTH-1:0] w_ext_q;
    logic signed [ACC_WIDTH-1:0] w_prod_i;
    logic signed [ACC_WIDTH-1:0] w_prod_q;
    logic signed [ACC_WIDTH-1:0] w_sum_i;
    logic signed [ACC_WIDTH-1:0] w_sum_q;
    logic [CNT_WIDTH-1:0]        w_cnt_inc;

    logic [1:0]                  w_state_d;
    logic signed [ACC_WIDTH-1:0] w_acc_i_d;
    logic signed [ACC_WIDTH-1:0] w_acc_q_d;
    logic [CNT_WIDTH-1:0]        w_cnt_d;
    logic                        w_dump;
    logic signed [ACC_WIDTH-1:0] w_dump_i;
    logic signed [ACC_WIDTH-1:0] w_dump_q;
    logic [CNT_WIDTH-1:0]        w_dump_cnt;
    logic                        w_sync_err;

    // Saturating add; one guard bit catches overflow in either direction.
    function automatic logic signed [ACC_WIDTH-1:0] sat_add(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic signed [ACC_WIDTH-1:0] b
    );
        logic [ACC_WIDTH:0] s;
        s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
            sat_add = s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            sat_add = s[ACC_WIDTH-1:0];
        end
    endfunction

    // Sign-extend before negating so the most negative sample negates cleanly.
    assign w_sign    = bus.rx_loc_prn ^ bus.rx_loc_boc;
    assign w_smp_sop = bus.rx_smp_valid & bus.rx_prn_sop;
    assign w_ext_i   = {{(ACC_WIDTH-SAMPLE_WIDTH){bus.rx_smp_i[SAMPLE_WIDTH-1]}}, bus.rx_smp_i};
    assign w_ext_q   = {{(ACC_WIDTH-SAMPLE_WIDTH){bus.rx_smp_q[SAMPLE_WIDTH-1]}}, bus.rx_smp_q};
    assign w_prod_i  = w_sign ? -w_ext_i : w_ext_i;
    assign w_prod_q  = w_sign ? -w_ext_q : w_ext_q;
    assign w_sum_i   = sat_add(r_acc_i, w_prod_i);
    assign w_sum_q   = sat_add(r_acc_q, w_prod_q);
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_ONE;

    // Period state machine: decides accumulate / reload / dump for each sample.
    always_comb begin
        w_state_d  = r_state;
        w_acc_i_d  = r_acc_i;
        w_acc_q_d  = r_acc_q;
        w_cnt_d    = r_cnt;
        w_dump     = 1'b0;
        w_dump_i   = w_prod_i;
        w_dump_q   = w_prod_q;
        w_dump_cnt = CNT_ONE;
        w_sync_err = 1'b0;
        if (!bus.rx_en) begin
            // Disable wins over everything and throws away the partial period.
            w_state_d = ST_IDLE;
            w_acc_i_d = '0;
            w_acc_q_d = '0;
            w_cnt_d   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_d = ST_WAIT_SOP;
                    w_acc_i_d = '0;
                    w_acc_q_d = '0;
                    w_cnt_d   = '0;
                end
                ST_WAIT_SOP: begin
                    // Accumulators are already zero whenever this state is entered.
                    if (w_smp_sop) begin
                        if (bus.rx_prn_eop) begin
                            w_dump = 1'b1;
                        end else begin
                            w_acc_i_d = w_prod_i;
                            w_acc_q_d = w_prod_q;
                            w_cnt_d   = CNT_ONE;
                            w_state_d = ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (bus.rx_smp_valid) begin
                        if (bus.rx_prn_sop) begin
                            // Lost code sync: restart the period on this sample.
                            w_sync_err = 1'b1;
                            if (bus.rx_prn_eop) begin
                                w_dump    = 1'b1;
                                w_acc_i_d = '0;
                                w_acc_q_d = '0;
                                w_cnt_d   = '0;
                                w_state_d = ST_WAIT_SOP;
                            end else begin
                                w_acc_i_d = w_prod_i;
                                w_acc_q_d = w_prod_q;
                                w_cnt_d   = CNT_ONE;
                            end
                        end else if (bus.rx_prn_eop) begin
                            w_dump     = 1'b1;
                            w_dump_i   = w_sum_i;
                            w_dump_q   = w_sum_q;
                            w_dump_cnt = w_cnt_inc;
                            w_acc_i_d  = '0;
                            w_acc_q_d  = '0;
                            w_cnt_d    = '0;
                            w_state_d  = ST_WAIT_SOP;
                        end else begin
                            w_acc_i_d = w_sum_i;
                            w_acc_q_d = w_sum_q;
                            w_cnt_d   = w_cnt_inc;
                        end
                    end
                end
                default: begin
                    w_state_d = ST_IDLE;
                    w_acc_i_d = '0;
                    w_acc_q_d = '0;
                    w_cnt_d   = '0;
                end
            endcase
        end
    end

    // Period state and running accumulators.
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            r_state <= ST_IDLE;
            r_acc_i <= '0;
            r_acc_q <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_acc_i <= w_acc_i_d;
            r_acc_q <= w_acc_q_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Dump register with valid/ready hold, overrun and sync-error pulses.
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            r_dump_valid <= 1'b0;
            r_corr_i     <= '0;
            r_corr_q     <= '0;
            r_smp_cnt    <= '0;
            r_overrun    <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_sync_err <= w_sync_err;
            if (w_dump) begin
                r_corr_i     <= w_dump_i;
                r_corr_q     <= w_dump_q;
                r_smp_cnt    <= w_dump_cnt;
                r_dump_valid <= 1'b1;
                // Only an unconsumed result counts as overwritten.
                r_overrun    <= r_dump_valid & ~bus.rx_dump_ready;
            end else begin
                r_overrun <= 1'b0;
                if (r_dump_valid && bus.rx_dump_ready) begin
                    r_dump_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.tx_dump_valid = r_dump_valid;
    assign bus.tx_corr_i     = r_corr_i;
    assign bus.tx_corr_q     = r_corr_q;
    assign bus.tx_smp_cnt    = r_smp_cnt;
    assign bus.tx_overrun    = r_overrun;
    assign bus.tx_sync_err   = r_sync_err;

endmodule
